// File: rtl/branch_resolver.sv
// branch_resolver
//
// Resolves conditional branches against the direction predictor in the
// five-stage pipeline. An ID-stage branch (PC, immediate, predicted direction)
// is captured into a one-entry EX slot. In EX its prediction is compared with
// the ALU's actual condition. The block drives the PC redirect and the IF/ID
// and ID/EX flushes for two cases: predicted-taken fetch steering from ID, and
// misprediction recovery from EX. Two saturating counters report the number of
// resolved branches and mispredictions.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   stall_i         load-use stall (IF/ID holds, ID/EX receives a bubble)
//   id_branch_i     ID instruction is a conditional branch
//   id_pred_i       predicted direction of the ID branch (1 = taken)
//   id_pc_i         PC of the ID instruction
//   id_imm_i        sign-extended branch immediate, halfword units
//   ex_taken_i      actual branch condition from the EX compare
//   ex_branch_o     a valid branch occupies EX
//   mispredict_o    EX branch direction differs from its prediction
//   redirect_o      PC mux selects redirect_pc_o
//   redirect_pc_o   next fetch PC when redirect_o is set, otherwise 0
//   flush_if_o      zero IF/ID at the next edge
//   flush_id_o      zero ID/EX at the next edge
//   branch_cnt_o    saturating count of resolved branches
//   miss_cnt_o      saturating count of mispredictions

module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             id_branch_i,
  input  logic             id_pred_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic             ex_taken_i,
  output logic             ex_branch_o,
  output logic             mispredict_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ex_v;
  logic            ex_pred;
  logic [XLEN-1:0] ex_tgt;
  logic [XLEN-1:0] ex_ft;
  logic [XLEN-1:0] id_tgt;
  logic [XLEN-1:0] id_ft;
  // Cleared by reset and set at the first edge after release. ID steering is
  // held off until then, so every output reads 0 on the first cycle out of
  // reset even if a predicted-taken branch is already sitting in ID.
  logic            live;

  assign id_tgt = id_pc_i + (id_imm_i << 1);
  assign id_ft  = id_pc_i + XLEN'(4);

  assign ex_branch_o  = ex_v;
  assign mispredict_o = ex_v & (ex_taken_i != ex_pred);

  // Both targets are computed in ID and carried along, so EX only has to
  // select between them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v    <= 1'b0;
      ex_pred <= 1'b0;
      ex_tgt  <= '0;
      ex_ft   <= '0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (stall_i || flush_id_o) begin
        ex_v <= 1'b0;
      end else begin
        ex_v    <= id_branch_i;
        ex_pred <= id_pred_i;
        ex_tgt  <= id_tgt;
        ex_ft   <= id_ft;
      end
    end
  end

  // The counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (ex_v && (branch_cnt_o != CNT_MAX)) begin
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      end
      if (mispredict_o && (miss_cnt_o != CNT_MAX)) begin
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
    end
  end

  // EX recovery takes priority. When it fires, the branch in ID is on the
  // wrong path and flush_id_o squashes it. Steering from ID only happens when
  // the ID branch is about to advance, which means it is not stalled.
  always_comb begin
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    flush_if_o    = 1'b0;
    flush_id_o    = 1'b0;
    if (mispredict_o) begin
      redirect_o    = 1'b1;
      redirect_pc_o = ex_taken_i ? ex_tgt : ex_ft;
      flush_if_o    = 1'b1;
      flush_id_o    = 1'b1;
    end else if (live && id_branch_i && id_pred_i && !stall_i) begin
      redirect_o    = 1'b1;
      redirect_pc_o = id_tgt;
      flush_if_o    = 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver
//
// Testbench for branch_resolver, instantiated with XLEN = 32 and CNT_W = 4 so
// that counter saturation is reachable. A reference model tracks the EX slot
// as the original branch (pc, immediate, prediction) and derives the expected
// redirect, flush and counter values arithmetically.

module tb_branch_resolver;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk;
  logic             rst;
  logic             stall_i;
  logic             id_branch_i;
  logic             id_pred_i;
  logic [XLEN-1:0]  id_pc_i;
  logic [XLEN-1:0]  id_imm_i;
  logic             ex_taken_i;
  logic             ex_branch_o;
  logic             mispredict_o;
  logic             redirect_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             flush_if_o;
  logic             flush_id_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  int vectors;
  int miscompares;

  // Reference model state
  bit          m_v;
  bit          m_pred;
  logic [31:0] m_pc;
  logic [31:0] m_imm;
  int          m_bcnt;
  int          m_mcnt;
  bit          m_live;

  branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .id_branch_i   (id_branch_i),
    .id_pred_i     (id_pred_i),
    .id_pc_i       (id_pc_i),
    .id_imm_i      (id_imm_i),
    .ex_taken_i    (ex_taken_i),
    .ex_branch_o   (ex_branch_o),
    .mispredict_o  (mispredict_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_if_o    (flush_if_o),
    .flush_id_o    (flush_id_o),
    .branch_cnt_o  (branch_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    m_v    = 1'b0;
    m_pred = 1'b0;
    m_pc   = '0;
    m_imm  = '0;
    m_bcnt = 0;
    m_mcnt = 0;
    m_live = 1'b0;
  endtask

  // Call this task 1 time unit after a rising edge. It drives one cycle of
  // inputs, checks every output mid-cycle against the model, and then advances
  // the model across the next edge.
  task automatic applyStimulus(input bit br, input bit pred, input logic [31:0] pc,
                               input logic [31:0] imm, input bit taken, input bit stall);
    bit          e_miss;
    bit          e_red;
    bit          e_fif;
    bit          e_fid;
    logic [31:0] e_pc;
    id_branch_i = br;
    id_pred_i   = pred;
    id_pc_i     = pc;
    id_imm_i    = imm;
    ex_taken_i  = taken;
    stall_i     = stall;
    #4;
    e_miss = m_v && (taken != m_pred);
    e_red  = 1'b0;
    e_fif  = 1'b0;
    e_fid  = 1'b0;
    e_pc   = '0;
    if (e_miss) begin
      e_red = 1'b1;
      e_fif = 1'b1;
      e_fid = 1'b1;
      e_pc  = taken ? (m_pc + m_imm * 32'd2) : (m_pc + 32'd4);
    end else if (m_live && br && pred && !stall) begin
      e_red = 1'b1;
      e_fif = 1'b1;
      e_pc  = pc + imm * 32'd2;
    end
    checkOutput("ex_branch",   64'(ex_branch_o),   64'(m_v));
    checkOutput("mispredict",  64'(mispredict_o),  64'(e_miss));
    checkOutput("redirect",    64'(redirect_o),    64'(e_red));
    checkOutput("redirect_pc", 64'(redirect_pc_o), 64'(e_pc));
    checkOutput("flush_if",    64'(flush_if_o),    64'(e_fif));
    checkOutput("flush_id",    64'(flush_id_o),    64'(e_fid));
    checkOutput("branch_cnt",  64'(branch_cnt_o),  64'(m_bcnt));
    checkOutput("miss_cnt",    64'(miss_cnt_o),    64'(m_mcnt));
    @(posedge clk);
    if (m_v && m_bcnt < CMAX) m_bcnt++;
    if (e_miss && m_mcnt < CMAX) m_mcnt++;
    if (stall || e_miss) begin
      m_v = 1'b0;
    end else begin
      m_v    = br;
      m_pred = pred;
      m_pc   = pc;
      m_imm  = imm;
    end
    m_live = 1'b1;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ex_branch"},  64'(ex_branch_o),   64'd0);
    checkOutput({tag, "_mispredict"}, 64'(mispredict_o),  64'd0);
    checkOutput({tag, "_redirect"},   64'(redirect_o),    64'd0);
    checkOutput({tag, "_redir_pc"},   64'(redirect_pc_o), 64'd0);
    checkOutput({tag, "_flush_if"},   64'(flush_if_o),    64'd0);
    checkOutput({tag, "_flush_id"},   64'(flush_id_o),    64'd0);
    checkOutput({tag, "_branch_cnt"}, 64'(branch_cnt_o),  64'd0);
    checkOutput({tag, "_miss_cnt"},   64'(miss_cnt_o),    64'd0);
  endtask

  // Asserts reset in mid-cycle while the ID branch would steer and the EX
  // slot (if valid) would mispredict. Outputs must drop to 0 immediately.
  // Reset is held across one edge and released just after it.
  task automatic doReset();
    id_branch_i = 1'b1;
    id_pred_i   = 1'b1;
    id_pc_i     = $urandom;
    id_imm_i    = $urandom;
    ex_taken_i  = ~m_pred;
    stall_i     = 1'b0;
    #2;
    rst = 1'b0;
    modelClear();
    #1;
    checkAllZero("rst_async");
    @(posedge clk);
    #1;
    checkAllZero("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    stall_i     = 1'b0;
    id_branch_i = 1'b0;
    id_pred_i   = 1'b0;
    id_pc_i     = '0;
    id_imm_i    = '0;
    ex_taken_i  = 1'b0;
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b1;

    // First cycle after release: a predicted-taken ID branch must not steer.
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    doReset();

    // Not taken, predicted correctly
    applyStimulus(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h108, 32'h0, 1'b0, 1'b0);
    checkOutput("tp1_bcnt", 64'(branch_cnt_o), 64'd1);
    checkOutput("tp1_mcnt", 64'(miss_cnt_o),   64'd0);
    doReset();

    // Predicted taken, actually not taken
    applyStimulus(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h110, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0);
    checkOutput("tp2_mcnt", 64'(miss_cnt_o), 64'd1);
    doReset();

    // Predicted not taken, actually taken; the younger ID branch is squashed
    applyStimulus(1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h200, 32'hFFFFFFFC, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h1F0, 32'h10,       1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h1F8, 32'h0,        1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h1FC, 32'h0,        1'b0, 1'b0);
    checkOutput("tp3_bcnt", 64'(branch_cnt_o), 64'd1);
    doReset();

    // Stall: predicted-taken branch held in ID for two cycles
    applyStimulus(1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h20, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h20, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h340, 32'h0,  1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h344, 32'h0,  1'b0, 1'b0);
    doReset();

    // Saturation: 17 mispredicted branches, each followed by its EX cycle
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h400 + 32'(i * 8), 32'h4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("sat_bcnt", 64'(branch_cnt_o), 64'd15);
    checkOutput("sat_mcnt", 64'(miss_cnt_o),   64'd15);
    doReset();

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(99) < 60), 1'($urandom), 32'($urandom),
                      32'($urandom), 1'($urandom), 1'($urandom_range(99) < 20));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
